// File: rtl/led_matrix_scan_tx.sv
// Row-scan transmitter: serializes one row MSB-first into a 74HC595-style chain, then blanks, latches, addresses.
// Optional idle watchdog that blanks a stalled panel: define SCAN_WATCHDOG_EN.
module led_matrix_scan_tx #(
  parameter int COLS      = 32,
  parameter int ROWS      = 16,
  parameter int CLK_DIV   = 4,
  parameter int BLANK_CYC = 2,
  parameter int WDOG_CYC  = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROWS-1:0]         row_onehot,
  input  logic [COLS-1:0]         col_data,
  input  logic                    row_valid,
  output logic                    row_ready,
  output logic                    sr_data,
  output logic                    sr_clk,
  output logic                    sr_latch,
  output logic                    oe_n,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    row_err
);

  localparam int AW = $clog2(ROWS);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(COLS);
  localparam int CW = $clog2(BLANK_CYC + CLK_DIV + 1);

  localparam logic [PW-1:0] PH_LAST    = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE    = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(COLS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BLANK = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [COLS-1:0] shreg;
  logic [AW-1:0]   row_idx;
  logic [AW-1:0]   enc_idx;
  logic [PW-1:0]   ph;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   cnt;
  logic            shown;
  logic            accept;
  logic            onehot_ok;
  logic            shift_done;

  // Handshake: a row transfers on the rising clk edge where row_valid & row_ready are both 1;
  // row_ready depends only on the state register, and inputs are ignored on every other edge.
  assign row_ready  = (state == IDLE);
  assign accept     = row_valid & row_ready;
  assign onehot_ok  = (row_onehot != '0) && ((row_onehot & (row_onehot - ROWS'(1))) == '0);
  assign shift_done = (ph == PH_LAST) && (bit_cnt == BIT_LAST);

  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_onehot[i]) enc_idx = AW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && onehot_ok) state_nxt = SHIFT;
      SHIFT:   if (shift_done) state_nxt = BLANK;
      BLANK:   if (cnt == BLANK_LAST) state_nxt = LATCH;
      LATCH:   if (cnt == LATCH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SCAN_WATCHDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYC);
  logic [15:0] wdog;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      row_idx  <= '0;
      ph       <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      shown    <= 1'b0;
      sr_data  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
      oe_n     <= 1'b1;
      row_addr <= '0;
      row_err  <= 1'b0;
`ifdef SCAN_WATCHDOG_EN
      wdog     <= '0;
`endif
    end else begin
      row_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ph      <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            if (onehot_ok) begin
              shreg   <= col_data;
              row_idx <= enc_idx;
              sr_data <= col_data[COLS-1];
              sr_clk  <= 1'b0;
            end else begin
              row_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // shreg[COLS-1] is always the bit currently on sr_data
          if (ph == PH_LAST) begin
            ph     <= '0;
            sr_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              sr_data <= 1'b0;
              oe_n    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= {shreg[COLS-2:0], 1'b0};
              sr_data <= shreg[COLS-2];
            end
          end else begin
            ph <= ph + PW'(1);
            if (ph == PH_RISE) sr_clk <= 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt      <= '0;
            sr_latch <= 1'b1;
            row_addr <= row_idx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LATCH: begin
          if (cnt == LATCH_LAST) begin
            cnt      <= '0;
            sr_latch <= 1'b0;
            shown    <= 1'b1;
            oe_n     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
`ifdef SCAN_WATCHDOG_EN
      // Saturating idle counter; blanking lasts until the next completed LATCH.
      if (state == IDLE && !row_valid) begin
        if (wdog != WDOG_LIM) begin
          wdog <= wdog + 16'd1;
          if (wdog + 16'd1 == WDOG_LIM) begin
            oe_n  <= 1'b1;
            shown <= 1'b0;
          end
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_tx.sv
// Directed/randomized bench for led_matrix_scan_tx; pin activity is decoded into words/queues and
// compared with values derived from the row timing rules.
module tb_led_matrix_scan_tx;
  localparam int COLS      = 32;
  localparam int ROWS      = 16;
  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
`ifdef SCAN_WATCHDOG_EN
  localparam int WDOG      = 100;
`else
  localparam int WDOG      = 65535;
`endif
  localparam int LAT       = 1 + COLS * 2 * CLK_DIV + BLANK_CYC + CLK_DIV;
  localparam int OE_RUN    = BLANK_CYC + CLK_DIV;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] row_onehot = '0;
  logic [COLS-1:0] col_data = '0;
  logic            row_valid = 1'b0;
  logic            row_ready, sr_data, sr_clk, sr_latch, oe_n, row_err;
  logic [3:0]      row_addr;

  led_matrix_scan_tx #(
    .COLS(COLS), .ROWS(ROWS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .WDOG_CYC(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_onehot(row_onehot), .col_data(col_data),
    .row_valid(row_valid), .row_ready(row_ready), .sr_data(sr_data), .sr_clk(sr_clk),
    .sr_latch(sr_latch), .oe_n(oe_n), .row_addr(row_addr), .row_err(row_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic bits_q[$];
  logic [3:0] addr_q[$];
  int   oe_q[$];
  int   rises, latch_hi, oe_run, err_pulses, addr_viol;
  logic p_clk, p_latch, p_oe;
  logic [3:0] p_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    bits_q.delete(); addr_q.delete(); oe_q.delete();
    rises = 0; latch_hi = 0; oe_run = 0; err_pulses = 0; addr_viol = 0;
    p_clk = sr_clk; p_latch = sr_latch; p_oe = oe_n; p_addr = row_addr;
  endtask

  // One clock of observation, sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (sr_clk && !p_clk) begin bits_q.push_back(sr_data); rises++; end
    if (sr_latch && !p_latch) addr_q.push_back(row_addr);
    if (sr_latch) latch_hi++;
    if (oe_n) oe_run++;
    else if (p_oe) begin oe_q.push_back(oe_run); oe_run = 0; end
    if (row_err) err_pulses++;
    if (!oe_n && !p_oe && row_addr != p_addr) addr_viol++;
    p_clk = sr_clk; p_latch = sr_latch; p_oe = oe_n; p_addr = row_addr;
  endtask

  function automatic int idx_of(input logic [15:0] oh);
    int r = -1;
    for (int i = 0; i < 16; i++) if (oh == (16'd1 << i)) r = i;
    return r;
  endfunction

  // driver: present a row, optionally wiggle inputs while busy, return cycles to ready
  task automatic send_row(input logic [15:0] oh, input logic [31:0] col, input bit noise,
                          output int lat);
    int n = 0;
    while (!row_ready && n < 1000) begin tick(); n++; end
    check("ready_before_send", row_ready, 1);
    row_onehot = oh; col_data = col; row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    lat = 1;
    while (!row_ready && lat < 1000) begin
      if (noise && lat < 150) begin
        row_valid = 1'b1; row_onehot = 16'($urandom); col_data = $urandom;
      end else begin
        row_valid = 1'b0;
      end
      tick(); lat++;
    end
    row_valid = 1'b0;
  endtask

  task automatic verify_row(input string tag, input logic [15:0] oh, input logic [31:0] col,
                            input int lat, input bit chk_oe);
    logic [31:0] word = '0;
    int nbits = bits_q.size();
    for (int i = 0; i < nbits; i++) word = {word[30:0], bits_q[i]};
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_rises"}, rises, COLS);
    check({tag, "_bits"}, word, col);
    check({tag, "_latch_cnt"}, addr_q.size(), 1);
    if (addr_q.size() > 0) check({tag, "_addr_at_latch"}, addr_q[0], idx_of(oh));
    check({tag, "_row_addr"}, row_addr, idx_of(oh));
    check({tag, "_latch_hi"}, latch_hi, CLK_DIV);
    check({tag, "_oe_n_end"}, oe_n, 0);
    check({tag, "_no_err"}, err_pulses, 0);
    check({tag, "_addr_stable"}, addr_viol, 0);
    if (chk_oe) begin
      check({tag, "_oe_runs"}, oe_q.size(), 1);
      if (oe_q.size() > 0) check({tag, "_oe_len"}, oe_q[0], OE_RUN);
    end
  endtask

  initial begin
    int lat, n, ones;
    logic [3:0]  sv_addr;
    logic        sv_oe;
    logic [15:0] ill[3];
    logic [15:0] oh;
    logic [31:0] col;
    longint acc[16];
    longint now;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_sr_data", sr_data, 0);
    check("rst_sr_clk", sr_clk, 0);
    check("rst_sr_latch", sr_latch, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_row_addr", row_addr, 0);
    check("rst_row_err", row_err, 0);
    rst_n = 1'b1;
    mon_clear();
    tick();
    check("rst_ready", row_ready, 1);

    // single row, sparse pattern
    mon_clear();
    send_row(16'h0004, 32'h8000_0001, 1'b0, lat);
    verify_row("single", 16'h0004, 32'h8000_0001, lat, 1'b0);
    check("single_bit_count", bits_q.size(), 32);
    ones = 0;
    for (int i = 0; i < bits_q.size(); i++) if (bits_q[i]) ones++;
    check("single_ones", ones, 2);
    if (bits_q.size() == 32) begin
      check("single_k0", bits_q[0], 1);
      check("single_k31", bits_q[31], 1);
    end

    // illegal row selects
    ill[0] = 16'h0000; ill[1] = 16'h0003;
    ill[2] = (16'd1 << $urandom_range(0, 7)) | (16'd1 << $urandom_range(8, 15));
    for (int k = 0; k < 3; k++) begin
      mon_clear();
      sv_addr = row_addr; sv_oe = oe_n;
      row_onehot = ill[k]; col_data = $urandom; row_valid = 1'b1;
      tick();
      row_valid = 1'b0;
      check("illegal_err_pulse", row_err, 1);
      tick();
      check("illegal_err_clear", row_err, 0);
      check("illegal_ready", row_ready, 1);
      repeat (5) tick();
      check("illegal_no_sr_clk", rises, 0);
      check("illegal_addr_kept", row_addr, sv_addr);
      check("illegal_oe_kept", oe_n, sv_oe);
      check("illegal_err_once", err_pulses, 1);
    end

    // random rows, alternating busy-time input noise
    for (int k = 0; k < 4; k++) begin
      oh = 16'd1 << $urandom_range(0, 15);
      col = $urandom;
      mon_clear();
      send_row(oh, col, k[0], lat);
      verify_row(k[0] ? "busy_noise" : "random", oh, col, lat, 1'b1);
    end

    // back-to-back with valid held high
    mon_clear();
    row_valid = 1'b1;
    for (int r = 0; r < 16; r++) begin
      n = 0;
      while (!row_ready && n < 1000) begin tick(); n++; end
      row_onehot = 16'd1 << r; col_data = 32'hFFFF_FFFF;
      @(posedge clk); now = $time;
      acc[r] = now / 10;
      tick();
      if (r == 15) row_valid = 1'b0;
    end
    n = 0;
    while (!row_ready && n < 1000) begin tick(); n++; end
    for (int r = 1; r < 16; r++) check("b2b_spacing", 32'(acc[r] - acc[r-1]), LAT);
    check("b2b_latches", addr_q.size(), 16);
    for (int r = 0; r < 16 && r < addr_q.size(); r++) check("b2b_addr", addr_q[r], r);
    check("b2b_oe_runs", oe_q.size(), 16);
    for (int r = 0; r < oe_q.size(); r++) check("b2b_oe_len", oe_q[r], OE_RUN);
    ones = 0;
    for (int i = 0; i < bits_q.size(); i++) if (bits_q[i]) ones++;
    check("b2b_rises", rises, 16 * COLS);
    check("b2b_ones", ones, 16 * COLS);
    check("b2b_addr_stable", addr_viol, 0);

    // reset in the middle of a shift
    row_onehot = 16'h0100; col_data = $urandom; row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    repeat (40) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sr_data", sr_data, 0);
    check("midrst_sr_clk", sr_clk, 0);
    check("midrst_sr_latch", sr_latch, 0);
    check("midrst_oe_n", oe_n, 1);
    check("midrst_row_addr", row_addr, 0);
    check("midrst_ready", row_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_clear();
    repeat (300) tick();
    check("midrst_no_latch", latch_hi, 0);
    check("midrst_no_clk", rises, 0);
    check("midrst_blanked", oe_n, 1);
    oh = 16'd1 << $urandom_range(0, 15);
    col = $urandom;
    mon_clear();
    send_row(oh, col, 1'b0, lat);
    verify_row("after_rst", oh, col, lat, 1'b0);

    // idle behaviour after a completed row
    n = 0;
    while (!oe_n && n < 300) begin tick(); n++; end
`ifdef SCAN_WATCHDOG_EN
    check("wdog_oe_rise", n, WDOG);
    check("wdog_blank", oe_n, 1);
    oh = 16'd1 << $urandom_range(0, 15);
    col = $urandom;
    mon_clear();
    send_row(oh, col, 1'b0, lat);
    verify_row("wdog_recover", oh, col, lat, 1'b0);
`else
    check("idle_oe_held", oe_n, 0);
    check("idle_cycles", n, 300);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
